// File: rtl/xyz_irq_pkg.sv
// rtl/xyz_irq_pkg.sv - register map constants and ACTIVE word packing for the interrupt aggregator
package xyz_irq_pkg;

  localparam int N_SRC_MAX        = 16;
  localparam int ACTIVE_VALID_BIT = 15;
  localparam int ID_W             = 4;

  localparam logic [2:0] ADDR_PENDING = 3'd0;
  localparam logic [2:0] ADDR_MASK    = 3'd1;
  localparam logic [2:0] ADDR_MODE    = 3'd2;
  localparam logic [2:0] ADDR_ACTIVE  = 3'd3;
  localparam logic [2:0] ADDR_RAW     = 3'd4;
  localparam logic [2:0] ADDR_HOLDOFF = 3'd5;

  function automatic logic [N_SRC_MAX-1:0] active_word(input logic valid, input logic [ID_W-1:0] id);
    logic [N_SRC_MAX-1:0] w;
    w                   = '0;
    w[ACTIVE_VALID_BIT] = valid;
    w[ID_W-1:0]         = id;
    return w;
  endfunction

endpackage

// File: rtl/xyz_irq_prio_enc.sv
// rtl/xyz_irq_prio_enc.sv - combinational lowest-index priority encoder
module xyz_irq_prio_enc
  import xyz_irq_pkg::*;
#(
  parameter int N_SRC = 8
) (
  input  logic [N_SRC-1:0] req,
  output logic             valid,
  output logic [ID_W-1:0]  id
);

  // Scan from the top down so the lowest set index is the last assignment.
  always_comb begin
    id    = '0;
    valid = |req;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[i]) id = ID_W'(i);
    end
  end

endmodule

// File: rtl/xyz_irq_ctrl.sv
// rtl/xyz_irq_ctrl.sv - Avalon-MM interrupt aggregator with level/edge latching, masking and post-ack hold-off
// Optional input synchronizers: define XYZ_IRQ_CTRL_SYNC_EN.
module xyz_irq_ctrl
  import xyz_irq_pkg::*;
#(
  parameter int N_SRC = 8,
  parameter int DW    = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_SRC-1:0] src,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [DW-1:0]    writedata,
  output logic [DW-1:0]    readdata,
  output logic             irq
);

  logic [N_SRC-1:0] s;
  logic [N_SRC-1:0] src_q;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] pend;
  logic [N_SRC-1:0] pend_nxt;
  logic [N_SRC-1:0] mask;
  logic [N_SRC-1:0] mode;
  logic [N_SRC-1:0] act;
  logic [N_SRC-1:0] w1c;
  logic [DW-1:0]    holdoff;
  logic [DW-1:0]    hcnt;
  logic [DW-1:0]    rd_nxt;
  logic [DW-1:0]    pend_w;
  logic [DW-1:0]    mask_w;
  logic [DW-1:0]    mode_w;
  logic [DW-1:0]    raw_w;
  logic             wr;
  logic             valid;
  logic [ID_W-1:0]  id;

`ifdef XYZ_IRQ_CTRL_SYNC_EN
  logic [N_SRC-1:0] sync1;
  logic [N_SRC-1:0] sync2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= src;
      sync2 <= sync1;
    end
  end

  assign s = sync2;
`else
  assign s = src;
`endif

  assign wr   = chipselect && !write_n;
  assign rise = s & ~src_q;
  assign act  = pend & mask;
  assign w1c  = (wr && address == ADDR_PENDING) ? writedata[N_SRC-1:0] : '0;

  // Edge bits: a rise in the same cycle as W1C keeps the bit set.
  assign pend_nxt = (mode & (rise | (pend & ~w1c))) | (~mode & s);

  xyz_irq_prio_enc #(.N_SRC(N_SRC)) u_prio_enc (
    .req   (act),
    .valid (valid),
    .id    (id)
  );

  always_comb begin
    pend_w = '0;
    mask_w = '0;
    mode_w = '0;
    raw_w  = '0;
    pend_w[N_SRC-1:0] = pend;
    mask_w[N_SRC-1:0] = mask;
    mode_w[N_SRC-1:0] = mode;
    raw_w[N_SRC-1:0]  = s;
    case (address)
      ADDR_PENDING: rd_nxt = pend_w;
      ADDR_MASK:    rd_nxt = mask_w;
      ADDR_MODE:    rd_nxt = mode_w;
      ADDR_ACTIVE:  rd_nxt = DW'(active_word(valid, id));
      ADDR_RAW:     rd_nxt = raw_w;
      ADDR_HOLDOFF: rd_nxt = holdoff;
      default:      rd_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      src_q    <= '0;
      pend     <= '0;
      mask     <= '0;
      mode     <= '0;
      holdoff  <= '0;
      hcnt     <= '0;
      irq      <= 1'b0;
      readdata <= '0;
    end else begin
      src_q    <= s;
      pend     <= pend_nxt;
      readdata <= rd_nxt;
      irq      <= valid && (hcnt == '0);
      if (wr && address == ADDR_MASK)    mask    <= writedata[N_SRC-1:0];
      if (wr && address == ADDR_MODE)    mode    <= writedata[N_SRC-1:0];
      if (wr && address == ADDR_HOLDOFF) holdoff <= writedata;
      if (wr && address == ADDR_PENDING) hcnt <= holdoff;
      else if (hcnt != '0)               hcnt <= hcnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_xyz_irq_ctrl.sv
// tb/tb_xyz_irq_ctrl.sv - scoreboard bench for xyz_irq_ctrl with directed vectors
module tb_xyz_irq_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  src = '0;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [15:0] writedata = '0;
  logic [15:0] readdata;
  logic        irq;

  typedef struct {
    bit          is_irq;
    logic [15:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  xyz_irq_ctrl #(.N_SRC(8), .DW(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .src        (src),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq)
  );

  always @(negedge clk) begin
    exp_t        e;
    logic [15:0] got;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      got = e.is_irq ? {15'b0, irq} : readdata;
      checks++;
      if (got !== e.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h", e.name, got, e.exp);
      end
    end
  end

  task automatic push(input bit is_irq, input logic [15:0] exp, input string name);
    exp_t e;
    e.is_irq = is_irq;
    e.exp    = exp;
    e.name   = name;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, input logic [15:0] e, input string name);
    address    = a;
    chipselect = 1'b1;
    tick();
    chipselect = 1'b0;
    push(1'b0, e, name);
  endtask

  task automatic exp_irq(input logic e, input string name);
    push(1'b1, {15'b0, e}, name);
  endtask

  initial begin
    // Reset state
    tick();
    reset_n = 1'b1;
    for (int a = 0; a < 8; a++) rd(3'(a), 16'h0000, $sformatf("reset_rd%0d", a));
    exp_irq(1'b0, "reset_irq");

    // Level mode on src[0]
    wr(3'd1, 16'h0001);
    src = 8'h01;
    tick();
    exp_irq(1'b0, "lvl_irq_1cyc");
    tick();
    exp_irq(1'b1, "lvl_irq_2cyc");
    rd(3'd3, 16'h8000, "lvl_active");
    rd(3'd4, 16'h0001, "lvl_raw");
    src = 8'h00;
    tick();
    exp_irq(1'b1, "lvl_irq_still");
    rd(3'd0, 16'h0000, "lvl_pend_clr");
    exp_irq(1'b0, "lvl_irq_drop");

    // Edge mode pulses on src[2] then src[1]
    wr(3'd2, 16'h0006);
    wr(3'd1, 16'h0006);
    src = 8'h04; tick(); src = 8'h00; tick();
    src = 8'h02; tick(); src = 8'h00; tick();
    rd(3'd0, 16'h0006, "edge_pend");
    rd(3'd3, 16'h8001, "edge_active");
    wr(3'd0, 16'h0002);
    rd(3'd3, 16'h8002, "edge_active_w1c");
    exp_irq(1'b1, "edge_irq");

    // Rise and W1C on the same bit in the same cycle
    src        = 8'h02;
    address    = 3'd0;
    writedata  = 16'h0002;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    src        = 8'h00;
    rd(3'd0, 16'h0006, "set_wins");

    // Hold-off gap of 10 cycles after a W1C
    wr(3'd5, 16'd10);
    rd(3'd5, 16'd10, "holdoff_rd");
    wr(3'd0, 16'h0002);
    exp_irq(1'b1, "ho_irq_at_ack");
    for (int i = 1; i <= 10; i++) begin
      tick();
      exp_irq(1'b0, $sformatf("ho_gap_%0d", i));
    end
    tick();
    exp_irq(1'b1, "ho_irq_back");

    // Restart of the count by a second write five cycles in
    wr(3'd0, 16'h0000);
    exp_irq(1'b1, "rs_irq_at_ack");
    for (int i = 1; i <= 4; i++) begin
      tick();
      exp_irq(1'b0, $sformatf("rs_gap_a%0d", i));
    end
    wr(3'd0, 16'h0000);
    exp_irq(1'b0, "rs_gap_a5");
    for (int i = 1; i <= 10; i++) begin
      tick();
      exp_irq(1'b0, $sformatf("rs_gap_b%0d", i));
    end
    tick();
    exp_irq(1'b1, "rs_irq_back");

    // Masking all sources with eight edge bits pending
    wr(3'd2, 16'h00FF);
    src = 8'hFF; tick(); src = 8'h00; tick();
    wr(3'd1, 16'h0000);
    wr(3'd3, 16'hFFFF);
    wr(3'd6, 16'hFFFF);
    rd(3'd0, 16'h00FF, "mask_pend");
    rd(3'd3, 16'h0000, "mask_active");
    exp_irq(1'b0, "mask_irq");
    rd(3'd1, 16'h0000, "ro_write_ignored_mask");

    // Asynchronous reset in the middle of a hold-off
    wr(3'd1, 16'h00FF);
    wr(3'd5, 16'd10);
    wr(3'd0, 16'h0001);
    tick();
    tick();
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    push(1'b0, 16'h0000, "async_rst_readdata");
    exp_irq(1'b0, "async_rst_irq");
    tick();
    reset_n = 1'b1;
    for (int a = 0; a < 6; a++) rd(3'(a), 16'h0000, $sformatf("post_rst_rd%0d", a));
    exp_irq(1'b0, "post_rst_irq");

    // Hold-off count must be cleared by reset
    wr(3'd1, 16'h0001);
    src = 8'h01;
    tick();
    tick();
    exp_irq(1'b1, "post_rst_hcnt_zero");
    src = 8'h00;

    repeat (3) tick();
    if (sb.size() != 0) begin
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
